// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared types and defaults for the round-robin requester
package rr_pkg;

  localparam int RR_NUM_CLIENTS = 4;
  localparam int RR_LEN_W       = 4;
  localparam int RR_DEPTH       = 4;
  localparam int CID_W          = $clog2(RR_NUM_CLIENTS);
  localparam int ERR_W          = 3;

  typedef enum int {
    ERR_OVF   = 0,
    ERR_SPUR  = 1,
    ERR_MULTI = 2
  } err_idx_e;

  typedef logic [RR_LEN_W-1:0] job_t;

  // LOAD has no register encoding: rem is matched against the FIFO head directly.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } client_state_e;

endpackage

// File: rtl/rr_req_client.sv
// rtl/rr_req_client.sv - one client: job FIFO, beat counter, req/done/full
module rr_req_client
  import rr_pkg::*;
#(
  parameter int LEN_W = RR_LEN_W,
  parameter int DEPTH = RR_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [LEN_W-1:0] push_len,
  input  logic             beat,
  output logic             req,
  output logic             done,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [LEN_W-1:0] rem, head_len;
  logic             full_now, pop, push_ok;
  client_state_e    state;

  always_comb begin
    head_len = mem[rd_ptr[AW-1:0]];
    full_now = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop      = beat && req && (rem == head_len);
    // A pop on the same cycle frees the slot the push needs.
    push_ok  = push && (!full_now || pop);
    drop     = push && full_now && !pop;
    wr_nxt   = wr_ptr + PW'(push_ok);
    rd_nxt   = rd_ptr + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rem    <= '0;
      state  <= ST_IDLE;
      done   <= 1'b0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      done   <= pop;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      state  <= (wr_nxt != rd_nxt) ? ST_ACTIVE : ST_IDLE;
      if (pop)
        rem <= '0;
      else if (beat && req)
        rem <= rem + LEN_W'(1);
    end
  end

  assign req = (state == ST_ACTIVE);

endmodule

// File: rtl/rr_requester.sv
// rtl/rr_requester.sv - request-side agent for the 4-way round-robin arbiter
module rr_requester
  import rr_pkg::*;
#(
  parameter int NUM_CLIENTS = RR_NUM_CLIENTS,
  parameter int LEN_W       = RR_LEN_W,
  parameter int DEPTH       = RR_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLIENTS-1:0]         push_i,
  input  logic [NUM_CLIENTS*LEN_W-1:0]   push_len_i,
  output logic [NUM_CLIENTS-1:0]         req_o,
  input  logic [NUM_CLIENTS-1:0]         gnt_i,
  output logic                           beat_valid_o,
  output logic [$clog2(NUM_CLIENTS)-1:0] beat_client_o,
  output logic [NUM_CLIENTS-1:0]         done_o,
  output logic [NUM_CLIENTS-1:0]         full_o,
  output logic [ERR_W-1:0]               err_o
);

  localparam int CW = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] legal, drop;
  logic                   multi, spur;
  logic [CW-1:0]          idx;

  always_comb begin
    multi = |(gnt_i & (gnt_i - NUM_CLIENTS'(1)));
    spur  = |(gnt_i & ~req_o);
    // A onehot violation voids every grant bit, including requested ones.
    legal = multi ? '0 : (gnt_i & req_o);
    idx   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++)
      if (legal[k]) idx = CW'(k);
  end

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_client
    rr_req_client #(
      .LEN_W (LEN_W),
      .DEPTH (DEPTH)
    ) u_client (
      .clk      (clk),
      .reset    (reset),
      .push     (push_i[k]),
      .push_len (push_len_i[k*LEN_W +: LEN_W]),
      .beat     (legal[k]),
      .req      (req_o[k]),
      .done     (done_o[k]),
      .full     (full_o[k]),
      .drop     (drop[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_valid_o  <= 1'b0;
      beat_client_o <= '0;
      err_o         <= '0;
    end else begin
      beat_valid_o <= |legal;
      if (|legal) beat_client_o <= idx;
      err_o[ERR_OVF]   <= err_o[ERR_OVF]   | (|drop);
      err_o[ERR_SPUR]  <= err_o[ERR_SPUR]  | spur;
      err_o[ERR_MULTI] <= err_o[ERR_MULTI] | multi;
    end
  end

endmodule

// File: tb/tb_rr_requester.sv
// tb/tb_rr_requester.sv - directed self-checking bench for rr_requester
module tb_rr_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  push_i;
  logic [15:0] push_len_i;
  logic [3:0]  req_o;
  logic [3:0]  gnt_i;
  logic        beat_valid_o;
  logic [1:0]  beat_client_o;
  logic [3:0]  done_o;
  logic [3:0]  full_o;
  logic [2:0]  err_o;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  int rr_ptr;

  rr_requester dut (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push_i),
    .push_len_i    (push_len_i),
    .req_o         (req_o),
    .gnt_i         (gnt_i),
    .beat_valid_o  (beat_valid_o),
    .beat_client_o (beat_client_o),
    .done_o        (done_o),
    .full_o        (full_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input int k, input logic [3:0] len);
    push_i = 4'b0;
    push_i[k] = 1'b1;
    push_len_i = 16'h0;
    push_len_i[k*4 +: 4] = len;
    step();
    push_i = 4'b0;
  endtask

  initial begin
    reset = 1'b1;
    push_i = 4'b0;
    push_len_i = 16'h0;
    gnt_i = 4'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_req", 32'(req_o), 32'h0);
    check("rst_bv", 32'(beat_valid_o), 32'h0);
    check("rst_bc", 32'(beat_client_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_full", 32'(full_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);

    // client 2, 4-beat job, continuous grant
    push_one(2, 4'd3);
    check("t1_req_up", 32'(req_o), 32'h4);
    gnt_i = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t1_bv", 32'(beat_valid_o), 32'h1);
      check("t1_bc", 32'(beat_client_o), 32'h2);
      check("t1_done", 32'(done_o), (i == 4) ? 32'h4 : 32'h0);
      check("t1_req", 32'(req_o), (i == 4) ? 32'h0 : 32'h4);
    end
    gnt_i = 4'b0;
    step();
    check("t1_bv_off", 32'(beat_valid_o), 32'h0);
    check("t1_done_off", 32'(done_o), 32'h0);

    // all four clients single-beat under a round-robin arbiter model
    push_i = 4'hF;
    push_len_i = 16'h0;
    step();
    push_i = 4'b0;
    check("t2_req_all", 32'(req_o), 32'hF);
    done_cnt = 0;
    rr_ptr = 0;
    for (int c = 0; c < 6; c++) begin
      gnt_i = 4'b0;
      for (int j = 0; j < 4; j++) begin
        if (gnt_i == 4'b0 && req_o[(rr_ptr + j) % 4]) begin
          gnt_i[(rr_ptr + j) % 4] = 1'b1;
          rr_ptr = (rr_ptr + j + 1) % 4;
        end
      end
      step();
      done_cnt += $countones(done_o);
    end
    gnt_i = 4'b0;
    step();
    check("t2_done_cnt", 32'(done_cnt), 32'd4);
    check("t2_req", 32'(req_o), 32'h0);
    check("t2_err", 32'(err_o), 32'h0);

    // client 0, 3 beats, grants on alternating cycles
    push_one(0, 4'd2);
    for (int i = 0; i < 6; i++) begin
      gnt_i = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
      check("t3_req", 32'(req_o), (i < 4) ? 32'h1 : 32'h0);
      check("t3_done", 32'(done_o), (i == 4) ? 32'h1 : 32'h0);
    end
    gnt_i = 4'b0;

    // client 1 overflow and drain
    for (int i = 0; i < 4; i++) push_one(1, 4'd0);
    check("t4_full", 32'(full_o), 32'h2);
    check("t4_err_pre", 32'(err_o), 32'h0);
    push_one(1, 4'd0);
    check("t4_err_ovf", 32'(err_o), 32'h1);
    check("t4_full_hold", 32'(full_o), 32'h2);
    done_cnt = 0;
    gnt_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      done_cnt += $countones(done_o);
    end
    gnt_i = 4'b0;
    step();
    done_cnt += $countones(done_o);
    check("t4_done_cnt", 32'(done_cnt), 32'd4);
    check("t4_req", 32'(req_o), 32'h0);
    check("t4_full_clr", 32'(full_o), 32'h0);

    // spurious grant, then onehot violation
    gnt_i = 4'b1000;
    step();
    gnt_i = 4'b0;
    check("t5_spur", 32'(err_o), 32'h3);
    check("t5_spur_bv", 32'(beat_valid_o), 32'h0);
    push_i = 4'b0011;
    push_len_i = 16'h0011;
    step();
    push_i = 4'b0;
    check("t5_req", 32'(req_o), 32'h3);
    gnt_i = 4'b0011;
    step();
    check("t5_multi", 32'(err_o), 32'h7);
    check("t5_multi_bv", 32'(beat_valid_o), 32'h0);
    check("t5_multi_done", 32'(done_o), 32'h0);
    gnt_i = 4'b0001;
    step();
    check("t5_c0_b1", 32'(done_o), 32'h0);
    step();
    check("t5_c0_b2", 32'(done_o), 32'h1);
    gnt_i = 4'b0010;
    step();
    check("t5_c1_b1", 32'(done_o), 32'h0);
    step();
    check("t5_c1_b2", 32'(done_o), 32'h2);
    check("t5_bc", 32'(beat_client_o), 32'h1);
    gnt_i = 4'b0;
    step();

    // reset mid-burst on client 3
    push_one(3, 4'd5);
    gnt_i = 4'b1000;
    step();
    step();
    gnt_i = 4'b0;
    check("t6_req_mid", 32'(req_o), 32'h8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_req", 32'(req_o), 32'h0);
    check("t6_err", 32'(err_o), 32'h0);
    check("t6_done", 32'(done_o), 32'h0);
    check("t6_full", 32'(full_o), 32'h0);
    step();
    check("t6_done_after", 32'(done_o), 32'h0);
    check("t6_req_after", 32'(req_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_requester.md
Name: rr_requester

Overview:
- Request-side agent for the 4-way round-robin arbiter. It sits on the other end of the req/gnt interface.
- Each client queues jobs locally. A job is a burst of N beats.
- The block drives one request line per client and consumes arbiter grants. One grant cycle moves one beat.
- It reports per-client completion and flags protocol violations seen on the grant bus.

Parameters:
- NUM_CLIENTS, 4, number of requesters; must match the arbiter width.
- LEN_W, 4, width of the job-length field; a job has len+1 beats (1..16).
- DEPTH, 4, pending-job FIFO entries per client; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- push_i  input  NUM_CLIENTS  per-client job enqueue strobe.
- push_len_i  input  NUM_CLIENTS*LEN_W  per-client job length; client k uses bits [k*LEN_W +: LEN_W].
- req_o  output  NUM_CLIENTS  request lines to the arbiter.
- gnt_i  input  NUM_CLIENTS  grant lines from the arbiter.
- beat_valid_o  output  1  registered; one beat was granted in the previous cycle.
- beat_client_o  output  $clog2(NUM_CLIENTS)  index of the client that owned that beat.
- done_o  output  NUM_CLIENTS  registered one-cycle pulse after a job's final beat.
- full_o  output  NUM_CLIENTS  client FIFO holds DEPTH jobs.
- err_o  output  3  sticky flags: [0] push dropped on full, [1] grant without request, [2] multiple grant bits asserted.

Behaviour:
- Reset values: req_o=0, beat_valid_o=0, beat_client_o=0, done_o=0, full_o=0, err_o=0. All FIFOs are empty and all beat counters are 0.
- Reset asserted mid-job flushes queued and in-progress jobs. No done_o pulse is produced for them.
- Per-client state: a FIFO of lengths, plus a beat counter `rem` loaded from the head entry.
- Per-client FSM:
  - IDLE: FIFO empty.
  - LOAD: head present and `rem` not loaded; this state lasts 0 cycles, because `rem` is loaded combinationally from the head.
  - ACTIVE: request asserted.
  - Simplification: req_o[k] = FIFO non-empty. It is a registered-state function with no combinational path from gnt_i.
- Push latency: push at edge t makes the entry visible at t+1, so req_o[k] rises at t+1 if the FIFO was empty.
- Beat rule: a beat is consumed on any cycle where gnt_i[k] & req_o[k]. Grants may be non-contiguous.
  - `rem` counts granted beats, 0..len.
  - On the granted beat where rem==len: pop the FIFO, clear rem, and assert done_o[k] next cycle.
  - req_o[k] stays high if another job is queued; otherwise it falls next cycle.
- Request hold: req_o[k] never drops while beats remain, regardless of grant gaps.
- beat_valid_o / beat_client_o: registered from the single legal grant, so they lag the grant by 1 cycle.
- Push while full and no pop that cycle: the job is dropped and err_o[0] is set.
  - Push and pop on the same cycle when full: the push is accepted and occupancy is unchanged.
- full_o[k] is registered occupancy == DEPTH.
- Wrap-around: FIFO pointers are log2(DEPTH)+1 bits; full/empty is taken from the MSB compare.
- Grant with req_o[k]=0: the grant is ignored and err_o[1] is set.
- More than one gnt_i bit set (onehot violation): no beat is consumed for any client, err_o[2] is set, and beat_valid_o=0.
- err_o bits clear only on reset.

Decomposition:
- Package rr_pkg: NUM_CLIENTS and LEN_W defaults, CID_W = $clog2(NUM_CLIENTS), an error-bit index enum (ERR_OVF, ERR_SPUR, ERR_MULTI), and a job_t typedef (logic [LEN_W-1:0]).
- Sub-module rr_req_client holds one client's FIFO, beat counter, req, done and full logic. It is instantiated NUM_CLIENTS times via generate.
- The top level holds grant checking, error flags and beat reporting.

Test Plan:
- Push client 2, len=3; hold gnt_i=4'b0100 continuously -> req_o[2] high for 4 grant cycles; beat_valid_o for 4 cycles with beat_client_o=2; done_o=4'b0100 one cycle after the 4th grant; req_o[2] low the cycle after that.
- Push all 4 clients len=0; drive the real round_robin arbiter -> each client gets exactly 1 beat; four done pulses total; req_o returns to 0; err_o=0.
- Push client 0 len=2, then grant it on alternating cycles -> req_o[0] stays high through the gaps; done_o[0] after the 3rd grant only.
- Push client 1 five times with DEPTH=4 and no grants -> full_o[1]=1 after 4 pushes; the 5th push sets err_o[0]; after granting 4 single-beat jobs, exactly 4 done pulses.
- gnt_i=4'b1000 with req_o=0 -> err_o[1]=1, no beat. gnt_i=4'b0011 with both requesting -> err_o[2]=1, no rem change.
- Reset for one cycle while client 3 is mid-burst (rem=2 of len=5) -> next cycle: req_o=0, FIFOs empty, err_o=0, no done pulse.
